pc_fetch_unit: RTL and testbench

//   Instruction-fetch stage feeding the 32-bit instruction ROM. Holds the program counter,

---
 rtl/pc_fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//   Instruction-fetch stage. It holds the program counter and drives the
//   instruction ROM address from it. The instruction the ROM returns is
//   captured into the IF/ID register. Decode receives it through a
//   valid/ready handshake.
//   Branch, jump and jr redirects squash one wrong-path slot.
//   An illegal next PC (misaligned, outside the text segment, or falling off
//   the end of the ROM) sends the unit into a sticky FAULT state. Only reset
//   leaves that state.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous active-low reset
//   Instruction_i       ROM data for address PC_o (same cycle)
//   PC_o                current PC / ROM address
//   Stall_i             hazard stall: hold PC and IF/ID
//   Branch_taken_i      taken branch from decode
//   Branch_target_i     branch target
//   Jump_i              j/jal from decode
//   Jump_index_i        26-bit jump index field
//   Jr_i                jr from decode
//   Jr_addr_i           jr register value
//   IFID_Instruction_o  registered instruction to decode
//   IFID_PC4_o          registered PC+4 of that instruction
//   IFID_valid_o        IF/ID holds a valid instruction
//   ID_ready_i          decode accepts IF/ID this cycle
//   Fault_o             sticky fetch fault
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
   parameter int unsigned          DATA_WIDTH   = 32,
   parameter int unsigned          MEMORY_DEPTH = 64,
   parameter logic [DATA_WIDTH-1:0] TEXT_BASE   = 32'h00400000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] Instruction_i,
   output logic [DATA_WIDTH-1:0] PC_o,
   input  logic                  Stall_i,
   input  logic                  Branch_taken_i,
   input  logic [DATA_WIDTH-1:0] Branch_target_i,
   input  logic                  Jump_i,
   input  logic [25:0]           Jump_index_i,
   input  logic                  Jr_i,
   input  logic [DATA_WIDTH-1:0] Jr_addr_i,
   output logic [DATA_WIDTH-1:0] IFID_Instruction_o,
   output logic [DATA_WIDTH-1:0] IFID_PC4_o,
   output logic                  IFID_valid_o,
   input  logic                  ID_ready_i,
   output logic                  Fault_o
);

   localparam int unsigned          DW        = DATA_WIDTH;
   localparam logic [DW-1:0]        TEXT_LAST = TEXT_BASE + DW'(4 * MEMORY_DEPTH - 4);
   localparam logic [DW-1:0]        NOP       = '0;

   typedef enum logic [0:0] {S_RUN = 1'b0, S_FAULT = 1'b1} state_e;

   state_e        state_q, state_d;
   logic [DW-1:0] pc_q, pc_d;
   logic [DW-1:0] ifid_instr_q, ifid_instr_d;
   logic [DW-1:0] ifid_pc4_q, ifid_pc4_d;
   logic          ifid_valid_q, ifid_valid_d;

   logic          hold_c;
   logic          redirect_c;
   logic [DW-1:0] target_c;
   logic          target_ok_c;
   logic [DW:0]   seq_sum_c;
   logic          seq_ok_c;
   logic          fault_evt_c;

   function automatic logic is_legal(input logic [DW-1:0] a);
      return (a[1:0] == 2'b00) && (a >= TEXT_BASE) && (a <= TEXT_LAST);
   endfunction

   // Redirect/sequential decision shared by the next-state and output logic
   always_comb begin
      hold_c      = Stall_i | (ifid_valid_q & ~ID_ready_i);
      // Redirects from a squashed (invalid) slot are ignored
      redirect_c  = ifid_valid_q & (Jr_i | Jump_i | Branch_taken_i);
      if (Jr_i)
         target_c = Jr_addr_i;
      else if (Jump_i)
         target_c = {ifid_pc4_q[DW-1:DW-4], Jump_index_i, 2'b00};
      else
         target_c = Branch_target_i;
      target_ok_c = is_legal(target_c);
      // Extra carry bit catches 32-bit wrap of PC+4
      seq_sum_c   = {1'b0, pc_q} + (DW+1)'(4);
      seq_ok_c    = ~seq_sum_c[DW] & is_legal(seq_sum_c[DW-1:0]);
      fault_evt_c = redirect_c ? ~target_ok_c : (~hold_c & ~seq_ok_c);
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_RUN;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RUN:   if (fault_evt_c) state_d = S_FAULT;
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_RUN;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      pc_d         = pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;
      case (state_q)
         S_RUN: begin
            if (fault_evt_c) begin
               // PC freezes; whatever sits in IF/ID is dropped
               ifid_instr_d = NOP;
               ifid_pc4_d   = NOP;
               ifid_valid_d = 1'b0;
            end else if (redirect_c) begin
               pc_d         = target_c;
               ifid_instr_d = NOP;
               ifid_pc4_d   = NOP;
               ifid_valid_d = 1'b0;
            end else if (!hold_c) begin
               pc_d         = seq_sum_c[DW-1:0];
               ifid_instr_d = Instruction_i;
               ifid_pc4_d   = seq_sum_c[DW-1:0];
               ifid_valid_d = 1'b1;
            end
         end
         default: begin
            ifid_instr_d = NOP;
            ifid_pc4_d   = NOP;
            ifid_valid_d = 1'b0;
         end
      endcase
   end

   // PC and IF/ID registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q         <= TEXT_BASE;
         ifid_instr_q <= NOP;
         ifid_pc4_q   <= NOP;
         ifid_valid_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

   assign PC_o               = pc_q;
   assign IFID_Instruction_o = ifid_instr_q;
   assign IFID_PC4_o         = ifid_pc4_q;
   assign IFID_valid_o       = ifid_valid_q;
   assign Fault_o            = (state_q == S_FAULT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//   Drives directed and randomized fetch traffic into pc_fetch_unit. A random
//   ROM supplies Instruction_i. Every cycle the outputs are compared against a
//   behavioural model of the fetch stage.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

   localparam logic [31:0] BASE  = 32'h00400000;
   localparam int unsigned DEPTH = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Instruction_i;
   logic [31:0] PC_o;
   logic        Stall_i;
   logic        Branch_taken_i;
   logic [31:0] Branch_target_i;
   logic        Jump_i;
   logic [25:0] Jump_index_i;
   logic        Jr_i;
   logic [31:0] Jr_addr_i;
   logic [31:0] IFID_Instruction_o;
   logic [31:0] IFID_PC4_o;
   logic        IFID_valid_o;
   logic        ID_ready_i;
   logic        Fault_o;

   logic [31:0] rom [DEPTH];

   int checks   = 0;
   int failures = 0;

   // Model state
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid, m_fault;

   pc_fetch_unit #(
      .DATA_WIDTH  (32),
      .MEMORY_DEPTH(DEPTH),
      .TEXT_BASE   (BASE)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .Instruction_i     (Instruction_i),
      .PC_o              (PC_o),
      .Stall_i           (Stall_i),
      .Branch_taken_i    (Branch_taken_i),
      .Branch_target_i   (Branch_target_i),
      .Jump_i            (Jump_i),
      .Jump_index_i      (Jump_index_i),
      .Jr_i              (Jr_i),
      .Jr_addr_i         (Jr_addr_i),
      .IFID_Instruction_o(IFID_Instruction_o),
      .IFID_PC4_o        (IFID_PC4_o),
      .IFID_valid_o      (IFID_valid_o),
      .ID_ready_i        (ID_ready_i),
      .Fault_o           (Fault_o)
   );

   always #5 clk = ~clk;

   // Combinational ROM read at the DUT's address
   assign Instruction_i = rom[6'((PC_o - BASE) >> 2)];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit legal(input logic [31:0] a);
      return (a % 4 == 0) && (a >= BASE) && (a < BASE + 4 * DEPTH);
   endfunction

   task automatic model_reset();
      m_pc = BASE; m_instr = '0; m_pc4 = '0; m_valid = 1'b0; m_fault = 1'b0;
   endtask

   // One clock of the fetch stage, from the rules in plain terms
   task automatic model_edge();
      logic [31:0] tgt;
      logic [32:0] seq;
      bit          redirect, hold;
      if (m_fault) return;
      redirect = m_valid && (Jr_i || Jump_i || Branch_taken_i);
      hold     = Stall_i || (m_valid && !ID_ready_i);
      if (Jr_i)        tgt = Jr_addr_i;
      else if (Jump_i) tgt = {m_pc4[31:28], Jump_index_i, 2'b00};
      else             tgt = Branch_target_i;
      seq = 33'(m_pc) + 33'd4;
      if (redirect) begin
         if (legal(tgt)) begin
            m_pc = tgt; m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
         end else begin
            m_fault = 1'b1; m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
         end
      end else if (!hold) begin
         if (seq < 33'(BASE + 4 * DEPTH)) begin
            m_instr = rom[(m_pc - BASE) / 4];
            m_pc4   = seq[31:0];
            m_pc    = seq[31:0];
            m_valid = 1'b1;
         end else begin
            m_fault = 1'b1; m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
         end
      end
   endtask

   task automatic compare_all();
      chk("PC_o", PC_o, m_pc);
      chk("IFID_Instruction_o", IFID_Instruction_o, m_instr);
      chk("IFID_PC4_o", IFID_PC4_o, m_pc4);
      chk("IFID_valid_o", 32'(IFID_valid_o), 32'(m_valid));
      chk("Fault_o", 32'(Fault_o), 32'(m_fault));
   endtask

   // Drive one cycle of inputs, advance model and DUT, compare after the edge
   task automatic cyc(input logic st, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [25:0] ix,
                      input logic jr, input logic [31:0] ja, input logic rdy);
      Stall_i = st; Branch_taken_i = br; Branch_target_i = bt;
      Jump_i = jp; Jump_index_i = ix; Jr_i = jr; Jr_addr_i = ja; ID_ready_i = rdy;
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic free(input int n);
      repeat (n) cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
   endtask

   // Asynchronous reset pulse away from the clock edge, checked immediately
   task automatic do_reset();
      #2 reset = 1'b0;
      model_reset();
      #1;
      compare_all();
      chk("reset_pc_now", PC_o, 32'h00400000);
      chk("reset_fault_now", 32'(Fault_o), 32'd0);
      @(posedge clk);
      #1;
      compare_all();
      reset = 1'b1;
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 9))
         0:       return BASE + 4 * DEPTH + 4 * $urandom_range(0, 15);
         1:       return BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
         2:       return BASE - 4;
         default: return BASE + 4 * $urandom_range(0, DEPTH - 1);
      endcase
   endfunction

   initial begin
      for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
      reset = 1'b0;
      Stall_i = 0; Branch_taken_i = 0; Branch_target_i = '0; Jump_i = 0;
      Jump_index_i = '0; Jr_i = 0; Jr_addr_i = '0; ID_ready_i = 1;
      model_reset();
      @(posedge clk);
      #1;
      compare_all();
      chk("rst_pc", PC_o, 32'h00400000);
      chk("rst_valid", 32'(IFID_valid_o), 32'd0);
      chk("rst_pc4", IFID_PC4_o, 32'd0);
      reset = 1'b1;

      // Free run
      free(1);
      chk("run1_pc", PC_o, 32'h00400004);
      chk("run1_pc4", IFID_PC4_o, 32'h00400004);
      chk("run1_instr", IFID_Instruction_o, rom[0]);
      free(1);
      chk("run2_pc", PC_o, 32'h00400008);

      // Stall three cycles at 0x400008
      repeat (3) cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
      chk("stall_pc", PC_o, 32'h00400008);
      chk("stall_pc4", IFID_PC4_o, 32'h00400008);
      free(1);
      chk("resume_pc", PC_o, 32'h0040000C);
      free(1);
      chk("pre_jump_pc4", IFID_PC4_o, 32'h00400010);

      // Jump
      cyc(1'b0, 1'b0, '0, 1'b1, 26'h0100010, 1'b0, '0, 1'b1);
      chk("jump_pc", PC_o, 32'h00400040);
      chk("jump_bubble", 32'(IFID_valid_o), 32'd0);
      free(1);
      chk("after_jump_pc", PC_o, 32'h00400044);

      // Branch with simultaneous stall
      cyc(1'b1, 1'b1, 32'h00400020, 1'b0, '0, 1'b0, '0, 1'b1);
      chk("branch_pc", PC_o, 32'h00400020);
      chk("branch_bubble", 32'(IFID_valid_o), 32'd0);
      free(1);
      chk("branch_instr", IFID_Instruction_o, rom[8]);
      chk("branch_valid", 32'(IFID_valid_o), 32'd1);

      // Jr beats Jump
      cyc(1'b0, 1'b0, '0, 1'b1, 26'h0100010, 1'b1, 32'h00400080, 1'b1);
      chk("jr_prio_pc", PC_o, 32'h00400080);
      free(1);

      // Backpressure holds IF/ID
      repeat (2) cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
      chk("bp_pc", PC_o, 32'h00400084);
      chk("bp_valid", 32'(IFID_valid_o), 32'd1);

      // Misaligned jr faults
      cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 32'h00400002, 1'b1);
      chk("mis_fault", 32'(Fault_o), 32'd1);
      chk("mis_pc", PC_o, 32'h00400084);
      chk("mis_valid", 32'(IFID_valid_o), 32'd0);
      repeat (3) cyc(1'($urandom), 1'b1, rand_addr(), 1'b0, '0, 1'b1, 32'h00400010, 1'b1);
      chk("fault_frozen_pc", PC_o, 32'h00400084);
      do_reset();

      // Jr past end of ROM
      free(1);
      cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 32'h00400100, 1'b1);
      chk("oor_fault", 32'(Fault_o), 32'd1);
      do_reset();

      // Fall-through past the last ROM word
      free(1);
      cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 32'h004000F8, 1'b1);
      free(1);
      chk("last_pc", PC_o, 32'h004000FC);
      chk("last_fault", 32'(Fault_o), 32'd0);
      free(1);
      chk("end_fault", 32'(Fault_o), 32'd1);
      chk("end_pc", PC_o, 32'h004000FC);
      do_reset();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ((m_fault && $urandom_range(0, 5) == 0) || $urandom_range(0, 499) == 0)
            do_reset();
         else
            cyc(1'($urandom_range(0, 4) == 0),
                1'($urandom_range(0, 9) == 0), rand_addr(),
                1'($urandom_range(0, 19) == 0), 26'((BASE >> 2) + $urandom_range(0, 70)),
                1'($urandom_range(0, 19) == 0), rand_addr(),
                1'($urandom_range(0, 3) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
